// File: rtl/phaser_lfo.sv
// Triangle-wave sweep generator for the phaser all-pass chain.
// Four-stage pipeline: phase step, triangle fold, depth scaling, centre offset with saturation.
module phaser_lfo #(
    parameter int PHASE_W = 24,
    parameter int RATE_W  = 16,
    parameter int COEF_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_strobe,
    input  logic              enable,
    input  logic              phase_clr,
    input  logic [RATE_W-1:0] rate,
    input  logic [COEF_W-1:0] depth,
    input  logic [COEF_W-1:0] center,
    output logic [COEF_W-1:0] coef_out,
    output logic              coef_valid
);

    localparam int PROD_W = 2 * COEF_W + 1;

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [COEF_W-1:0]  depth1_q, depth1_d, depth2_q, depth2_d;
    logic [COEF_W-1:0]  center1_q, center1_d, center2_q, center2_d, center3_q, center3_d;
    logic [COEF_W-1:0]  tri_q, tri_d;
    logic [COEF_W-1:0]  scaled_q, scaled_d;
    logic [COEF_W-1:0]  coef_q, coef_d;
    logic               coef_valid_q, coef_valid_d;

    logic [COEF_W-1:0]        phase_u;
    logic [COEF_W-1:0]        tri_s;
    logic signed [PROD_W-1:0] tri_x, depth_x, prod;
    logic [COEF_W:0]          sum;

    always_comb begin
        // Clear is independent of the strobe; the add only happens on an enabled strobe.
        phase_d = phase_q;
        if (phase_clr) begin
            phase_d = '0;
        end else if (sample_strobe && enable) begin
            phase_d = phase_q + PHASE_W'(rate);
        end
        v1_d      = sample_strobe;
        depth1_d  = depth;
        center1_d = center;

        phase_u   = phase_q[PHASE_W-2 -: COEF_W];
        tri_d     = phase_q[PHASE_W-1] ? ~phase_u : phase_u;
        v2_d      = v1_q;
        depth2_d  = depth1_q;
        center2_d = center1_q;

        // Offset-binary to two's complement, then a floor-rounded gain of depth/2^COEF_W.
        tri_s     = {~tri_q[COEF_W-1], tri_q[COEF_W-2:0]};
        tri_x     = {{(PROD_W-COEF_W){tri_s[COEF_W-1]}}, tri_s};
        depth_x   = {{(PROD_W-COEF_W){1'b0}}, depth2_q};
        prod      = tri_x * depth_x;
        scaled_d  = COEF_W'(prod >>> COEF_W);
        v3_d      = v2_q;
        center3_d = center2_q;

        sum = {center3_q[COEF_W-1], center3_q} + {scaled_q[COEF_W-1], scaled_q};
        coef_d = coef_q;
        if (v3_q) begin
            if (sum[COEF_W] != sum[COEF_W-1]) begin
                coef_d = sum[COEF_W] ? {1'b1, {(COEF_W-1){1'b0}}} : {1'b0, {(COEF_W-1){1'b1}}};
            end else begin
                coef_d = sum[COEF_W-1:0];
            end
        end
        coef_valid_d = v3_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v3_q         <= 1'b0;
            depth1_q     <= '0;
            depth2_q     <= '0;
            center1_q    <= '0;
            center2_q    <= '0;
            center3_q    <= '0;
            tri_q        <= '0;
            scaled_q     <= '0;
            coef_q       <= '0;
            coef_valid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            v3_q         <= v3_d;
            depth1_q     <= depth1_d;
            depth2_q     <= depth2_d;
            center1_q    <= center1_d;
            center2_q    <= center2_d;
            center3_q    <= center3_d;
            tri_q        <= tri_d;
            scaled_q     <= scaled_d;
            coef_q       <= coef_d;
            coef_valid_q <= coef_valid_d;
        end
    end

    assign coef_out   = coef_q;
    assign coef_valid = coef_valid_q;

endmodule

// File: tb/tb_phaser_lfo.sv
// Bench for phaser_lfo: directed vector table, hand sequences and random traffic,
// all scored against an arithmetic model of the sweep.
module tb_phaser_lfo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_strobe = 1'b0;
    logic        enable = 1'b0;
    logic        phase_clr = 1'b0;
    logic [15:0] rate = '0;
    logic [11:0] depth = '0;
    logic [11:0] center = '0;
    logic [11:0] coef_out;
    logic        coef_valid;

    always #5 clk = ~clk;

    phaser_lfo dut (
        .clk           (clk),
        .reset         (reset),
        .sample_strobe (sample_strobe),
        .enable        (enable),
        .phase_clr     (phase_clr),
        .rate          (rate),
        .depth         (depth),
        .center        (center),
        .coef_out      (coef_out),
        .coef_valid    (coef_valid)
    );

    typedef struct {
        int due;
        int val;
    } exp_t;

    typedef struct {
        bit rst, stb, en, clr;
        int rt, dp, cn;
        bit chk, ev;
        int ec;
    } vec_t;

    exp_t   exp_q[$];
    vec_t   tbl[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     cyc_n = 0;
    int     last_exp = 0;
    int     exp_valid = 0;
    int     exp_coef = 0;
    longint ref_phase = 0;

    // Coefficient the sweep should produce for a given phase, from plain arithmetic.
    function automatic int ref_coef(longint ph, int dp, int cn);
        int u, tri_v, p, s, total;
        u     = int'((ph / 2048) % 4096);
        tri_v = (ph >= 64'd8388608) ? 4095 - u : u;
        p     = (tri_v - 2048) * dp;
        s     = p / 4096;
        if (p < 0 && (p % 4096) != 0) s = s - 1;
        total = cn + s;
        if (total > 2047) total = 2047;
        if (total < -2048) total = -2048;
        return total;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc_n);
    endtask

    task automatic cyc(input bit rst, input bit stb, input bit en, input bit clr,
                       input int rt, input int dp, input int cn);
        reset         = rst;
        sample_strobe = stb;
        enable        = en;
        phase_clr     = clr;
        rate          = 16'(rt);
        depth         = 12'(dp);
        center        = 12'(cn);
        @(posedge clk);
        cyc_n++;
        if (rst) begin
            ref_phase = 0;
            exp_q.delete();
            last_exp  = 0;
            exp_valid = 0;
            exp_coef  = 0;
        end else begin
            exp_valid = 0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc_n) begin
                exp_valid = 1;
                last_exp  = exp_q[0].val;
                void'(exp_q.pop_front());
            end
            exp_coef = last_exp;
            if (clr) ref_phase = 0;
            else if (stb && en) ref_phase = (ref_phase + longint'(rt)) % 64'd16777216;
            if (stb) exp_q.push_back('{cyc_n + 3, ref_coef(ref_phase, dp, cn)});
        end
        #1;
        check("model_valid", int'(coef_valid), exp_valid);
        check("model_coef", int'($signed(coef_out)), exp_coef);
    endtask

    initial begin
        int pulses;
        // rst stb en clr rate depth center | chk valid coef
        tbl.push_back('{1, 0, 0, 0, 0,       0,    0,     1, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0,       4095, 0,     1, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0,       4095, 0,     1, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0,       4095, 0,     1, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0,       4095, 0,     1, 1, -2048});
        tbl.push_back('{0, 0, 1, 0, 0,       4095, 0,     1, 0, -2048});
        tbl.push_back('{0, 1, 1, 1, 'h1000,  4095, 0,     1, 0, -2048});
        tbl.push_back('{0, 1, 1, 0, 'h1000,  4095, 0,     1, 0, -2048});
        tbl.push_back('{0, 0, 1, 0, 'h1000,  4095, 0,     1, 0, -2048});
        tbl.push_back('{0, 0, 1, 0, 'h1000,  4095, 0,     1, 1, -2048});
        tbl.push_back('{0, 0, 1, 0, 'h1000,  4095, 0,     1, 1, -2046});
        tbl.push_back('{0, 0, 1, 0, 'h1000,  4095, 0,     1, 0, -2046});
        tbl.push_back('{0, 1, 1, 1, 0,       4095, -1000, 1, 0, -2046});
        tbl.push_back('{0, 0, 1, 0, 0,       4095, -1000, 1, 0, -2046});
        tbl.push_back('{0, 0, 1, 0, 0,       4095, -1000, 1, 0, -2046});
        tbl.push_back('{0, 0, 1, 0, 0,       4095, -1000, 1, 1, -2048});
        tbl.push_back('{0, 0, 1, 1, 0,       4095, 0,     1, 0, -2048});
        tbl.push_back('{0, 1, 1, 0, 'h800,   4095, 0,     1, 0, -2048});
        tbl.push_back('{0, 0, 1, 0, 'h800,   4095, 0,     1, 0, -2048});
        tbl.push_back('{0, 0, 1, 0, 'h800,   4095, 0,     1, 0, -2048});
        tbl.push_back('{0, 0, 1, 0, 'h800,   4095, 0,     1, 1, -2047});
        tbl.push_back('{0, 0, 1, 0, 'h800,   4095, 0,     1, 0, -2047});

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].stb, tbl[i].en, tbl[i].clr, tbl[i].rt, tbl[i].dp, tbl[i].cn);
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_valid", i), int'(coef_valid), int'(tbl[i].ev));
                check($sformatf("tbl%0d_coef", i), int'($signed(coef_out)), tbl[i].ec);
            end
        end

        // Positive saturation at the sweep peak (phase 0x7FF800 = 195 * 0xA800).
        cyc(0, 0, 1, 1, 0, 4095, 1000);
        for (int i = 0; i < 195; i++) cyc(0, 1, 1, 0, 'hA800, 4095, 1000);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 4095, 1000);
        check("sat_hi_valid", int'(coef_valid), 1);
        check("sat_hi_coef", int'($signed(coef_out)), 2047);

        // Full sweep from reset including the wrap at the top of the phase range.
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8200; i++) begin
            cyc(0, 1, 1, 0, 'h800, 4095, 0);
            if (i == 4 || i == 8196) check("sweep_step1", int'($signed(coef_out)), -2047);
            if (i == 4098) check("sweep_peak", int'($signed(coef_out)), 2046);
            if (i == 8194 || i == 8195) check("sweep_wrap", int'($signed(coef_out)), -2048);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 4095, 0);

        // Frozen phase: every strobe still yields a pulse; centre change applies to later strobes.
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            if (i < 10) cyc(0, 1, 0, 0, 'h1234, 3000, (i < 5) ? 0 : 100);
            else cyc(0, 0, 0, 0, 'h1234, 3000, 100);
            if (coef_valid) pulses++;
        end
        check("freeze_pulses", pulses, 10);

        // Reset while three samples are in flight.
        cyc(0, 1, 1, 0, 'h3000, 2000, 300);
        cyc(0, 1, 1, 0, 'h3000, 2000, 300);
        cyc(1, 1, 1, 0, 'h3000, 2000, 300);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 0, 4095, 0);
            if (coef_valid) pulses++;
        end
        check("rst_pulses", pulses, 0);
        check("rst_coef", int'($signed(coef_out)), 0);
        cyc(0, 1, 1, 0, 0, 4095, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 4095, 0);
        check("after_rst_valid", int'(coef_valid), 1);
        check("after_rst_coef", int'($signed(coef_out)), -2048);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                int'($urandom_range(0, 65535)), int'($urandom_range(0, 4095)),
                int'($urandom_range(0, 4095)) - 2048);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
